sb_fpga_axi_arb: RTL and testbench

//  Shares one 512-bit AXI4 master port between N switchboard FPGA queue engines (sb_rx_fpga/sb_tx_fpga).
//  The read path (AR/R) and write path (AW/W/B) each have their own round-robin arbiter.

---
 rtl/sb_fpga_axi_arb.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sb_fpga_axi_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_fpga_axi_arb.sv
`default_nettype none
// ============================================================================
// Module     : sb_fpga_axi_arb
// Description: Shares one 512-bit AXI4 master port between N queue engines.
//              Independent round-robin arbiters for the read (AR/R) and
//              write (AW/W/B) paths. Each grant is held until its transaction
//              completes, so IDs pass through unmodified.
// Revision   : 1.0 - initial release
// ============================================================================
module sb_fpga_axi_arb #(
  parameter int N        = 2,
  parameter int ID_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  // client AW
  input  logic [N*ID_WIDTH-1:0] s_axi_awid,
  input  logic [N*64-1:0]       s_axi_awaddr,
  input  logic [N*8-1:0]        s_axi_awlen,
  input  logic [N*3-1:0]        s_axi_awsize,
  input  logic [N-1:0]          s_axi_awvalid,
  output logic [N-1:0]          s_axi_awready,
  // client W
  input  logic [N*512-1:0]      s_axi_wdata,
  input  logic [N*64-1:0]       s_axi_wstrb,
  input  logic [N-1:0]          s_axi_wlast,
  input  logic [N-1:0]          s_axi_wvalid,
  output logic [N-1:0]          s_axi_wready,
  // client B
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic [N-1:0]          s_axi_bvalid,
  input  logic [N-1:0]          s_axi_bready,
  // client AR
  input  logic [N*ID_WIDTH-1:0] s_axi_arid,
  input  logic [N*64-1:0]       s_axi_araddr,
  input  logic [N*8-1:0]        s_axi_arlen,
  input  logic [N*3-1:0]        s_axi_arsize,
  input  logic [N-1:0]          s_axi_arvalid,
  output logic [N-1:0]          s_axi_arready,
  // client R
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [511:0]          s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic [N-1:0]          s_axi_rvalid,
  input  logic [N-1:0]          s_axi_rready,
  // master AW
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [63:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // master W
  output logic [511:0]          m_axi_wdata,
  output logic [63:0]           m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // master B
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // master AR
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [63:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // master R
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [511:0]          m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // status
  output logic [N-1:0]          status_wr_grant,
  output logic [N-1:0]          status_rd_grant,
  output logic                  status_idle
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

  wr_state_t         wr_state_q, wr_state_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic [PW-1:0]     wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;

  // First requester strictly after ptr, cyclically; the last client served is checked last.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    int            idx;
    pick = '0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) pick = PW'(idx);
    end
    return pick;
  endfunction

  // B and R payloads are broadcast; only the valid is steered to the owner.
  assign s_axi_bid   = m_axi_bid;
  assign s_axi_bresp = m_axi_bresp;
  assign s_axi_rid   = m_axi_rid;
  assign s_axi_rdata = m_axi_rdata;
  assign s_axi_rresp = m_axi_rresp;
  assign s_axi_rlast = m_axi_rlast;

  // Write path: arbitration, AW/W forwarding with done tracking, B steering.
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_grant_d    = wr_grant_q;
    wr_ptr_d      = wr_ptr_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    m_axi_awid    = '0;
    m_axi_awaddr  = '0;
    m_axi_awlen   = '0;
    m_axi_awsize  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    s_axi_awready = '0;
    s_axi_wready  = '0;
    s_axi_bvalid  = '0;
    if (wr_state_q != W_IDLE) begin
      m_axi_awid   = s_axi_awid[wr_grant_q*ID_WIDTH +: ID_WIDTH];
      m_axi_awaddr = s_axi_awaddr[wr_grant_q*64 +: 64];
      m_axi_awlen  = s_axi_awlen[wr_grant_q*8 +: 8];
      m_axi_awsize = s_axi_awsize[wr_grant_q*3 +: 3];
      m_axi_wdata  = s_axi_wdata[wr_grant_q*512 +: 512];
      m_axi_wstrb  = s_axi_wstrb[wr_grant_q*64 +: 64];
      m_axi_wlast  = s_axi_wlast[wr_grant_q];
    end
    case (wr_state_q)
      W_IDLE: begin
        if (|s_axi_awvalid) begin
          wr_grant_d = rr_pick(s_axi_awvalid, wr_ptr_q);
          wr_state_d = W_XFER;
        end
      end
      W_XFER: begin
        m_axi_awvalid             = s_axi_awvalid[wr_grant_q] & ~aw_done_q;
        m_axi_wvalid              = s_axi_wvalid[wr_grant_q] & ~w_done_q;
        s_axi_awready[wr_grant_q] = m_axi_awready & ~aw_done_q;
        s_axi_wready[wr_grant_q]  = m_axi_wready & ~w_done_q;
        aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d  = w_done_q | (m_axi_wvalid & m_axi_wready & m_axi_wlast);
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid[wr_grant_q] = m_axi_bvalid;
        m_axi_bready             = s_axi_bready[wr_grant_q];
        if (m_axi_bvalid && m_axi_bready) begin
          wr_state_d = W_IDLE;
          wr_ptr_d   = wr_grant_q;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read path: arbitration, AR forwarding, R steering until the last beat.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_grant_d    = rd_grant_q;
    rd_ptr_d      = rd_ptr_q;
    m_axi_arid    = '0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    if (rd_state_q != R_IDLE) begin
      m_axi_arid   = s_axi_arid[rd_grant_q*ID_WIDTH +: ID_WIDTH];
      m_axi_araddr = s_axi_araddr[rd_grant_q*64 +: 64];
      m_axi_arlen  = s_axi_arlen[rd_grant_q*8 +: 8];
      m_axi_arsize = s_axi_arsize[rd_grant_q*3 +: 3];
    end
    case (rd_state_q)
      R_IDLE: begin
        if (|s_axi_arvalid) begin
          rd_grant_d = rr_pick(s_axi_arvalid, rd_ptr_q);
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_axi_arvalid             = s_axi_arvalid[rd_grant_q];
        s_axi_arready[rd_grant_q] = m_axi_arready;
        if (m_axi_arvalid && m_axi_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid[rd_grant_q] = m_axi_rvalid;
        m_axi_rready             = s_axi_rready[rd_grant_q];
        if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
          rd_state_d = R_IDLE;
          rd_ptr_d   = rd_grant_q;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Status is derived purely from registered state and grant.
  always_comb begin
    status_wr_grant = '0;
    status_rd_grant = '0;
    if (wr_state_q != W_IDLE) status_wr_grant[wr_grant_q] = 1'b1;
    if (rd_state_q != R_IDLE) status_rd_grant[rd_grant_q] = 1'b1;
    status_idle = (wr_state_q == W_IDLE) && (rd_state_q == R_IDLE);
  end

  // Write-side state; pointer resets to N-1 so client 0 wins first.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_state_q <= W_IDLE;
      wr_grant_q <= '0;
      wr_ptr_q   <= PW'(N - 1);
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Read-side state; pointer resets to N-1 so client 0 wins first.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_state_q <= R_IDLE;
      rd_grant_q <= '0;
      rd_ptr_q   <= PW'(N - 1);
    end else begin
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sb_fpga_axi_arb.sv
`default_nettype none
// ============================================================================
// Module     : tb_sb_fpga_axi_arb
// Description: Directed self-checking bench for sb_fpga_axi_arb (N=2).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_sb_fpga_axi_arb;
  localparam int N  = 2;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic nreset;

  logic [N*IW-1:0]  s_axi_awid, s_axi_arid;
  logic [N*64-1:0]  s_axi_awaddr, s_axi_araddr, s_axi_wstrb;
  logic [N*8-1:0]   s_axi_awlen, s_axi_arlen;
  logic [N*3-1:0]   s_axi_awsize, s_axi_arsize;
  logic [N*512-1:0] s_axi_wdata;
  logic [N-1:0]     s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [N-1:0]     s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic [N-1:0]     s_axi_rvalid, s_axi_rready;
  logic [IW-1:0]    s_axi_bid, s_axi_rid;
  logic [1:0]       s_axi_bresp, s_axi_rresp;
  logic [511:0]     s_axi_rdata;
  logic             s_axi_rlast;

  logic [IW-1:0]    m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [63:0]      m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic [7:0]       m_axi_awlen, m_axi_arlen;
  logic [2:0]       m_axi_awsize, m_axi_arsize;
  logic             m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [511:0]     m_axi_wdata, m_axi_rdata;
  logic [1:0]       m_axi_bresp, m_axi_rresp;
  logic             m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic             m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [N-1:0]     status_wr_grant, status_rd_grant;
  logic             status_idle;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  sb_fpga_axi_arb #(.N(N), .ID_WIDTH(IW)) dut (
    .clk(clk), .nreset(nreset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .status_wr_grant(status_wr_grant), .status_rd_grant(status_rd_grant),
    .status_idle(status_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow a 1-unit settle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // ---------------- Reset with every valid/ready high ----------------
    nreset = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = '1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_awvalid = '1; s_axi_wvalid = '1; s_axi_arvalid = '1;
    s_axi_bready = '1; s_axi_rready = '1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b1;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b1; m_axi_rvalid = 1'b1;
    step(); step();
    #1;
    check("rst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst_m_wvalid",  64'(m_axi_wvalid),  64'd0);
    check("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_m_bready",  64'(m_axi_bready),  64'd0);
    check("rst_m_rready",  64'(m_axi_rready),  64'd0);
    check("rst_s_awready", 64'(s_axi_awready), 64'd0);
    check("rst_s_wready",  64'(s_axi_wready),  64'd0);
    check("rst_s_arready", 64'(s_axi_arready), 64'd0);
    check("rst_s_bvalid",  64'(s_axi_bvalid),  64'd0);
    check("rst_s_rvalid",  64'(s_axi_rvalid),  64'd0);
    check("rst_m_awaddr",  m_axi_awaddr,       64'd0);
    check("rst_idle",      64'(status_idle),   64'd1);
    check("rst_wr_grant",  64'(status_wr_grant), 64'd0);
    check("rst_rd_grant",  64'(status_rd_grant), 64'd0);
    s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_arvalid = '0;
    s_axi_bready = '0; s_axi_rready = '0; s_axi_wlast = '0;
    m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    nreset = 1'b1;
    step();

    // ---------------- Single write from client 1 ----------------
    s_axi_awaddr[64 +: 64] = 64'h1000;
    s_axi_awid[IW +: IW]   = 16'h0055;
    s_axi_awsize[3 +: 3]   = 3'd6;
    s_axi_wstrb[64 +: 64]  = 64'hff;
    s_axi_wdata[512 +: 64] = 64'hdead_beef_0123_4567;
    s_axi_wlast  = 2'b10;
    s_axi_awvalid = 2'b10; s_axi_wvalid = 2'b10;
    #1;
    check("wr1_arb_latency", 64'(m_axi_awvalid), 64'd0);
    step(); #1;
    check("wr1_grant_xfer", 64'(status_wr_grant), 64'b10);
    check("wr1_m_awvalid",  64'(m_axi_awvalid), 64'd1);
    check("wr1_m_awaddr",   m_axi_awaddr,       64'h1000);
    check("wr1_m_awid",     64'(m_axi_awid),    64'h55);
    check("wr1_m_wstrb",    m_axi_wstrb,        64'hff);
    check("wr1_m_wdata",    m_axi_wdata[63:0],  64'hdead_beef_0123_4567);
    check("wr1_s_awready",  64'(s_axi_awready), 64'b10);
    check("wr1_s_wready",   64'(s_axi_wready),  64'b10);
    step();
    s_axi_awvalid = '0; s_axi_wvalid = '0;
    m_axi_bvalid = 1'b1; m_axi_bid = 16'h0055; m_axi_bresp = 2'b00;
    s_axi_bready = 2'b11;
    #1;
    check("wr1_resp_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("wr1_resp_grant",   64'(status_wr_grant), 64'b10);
    check("wr1_s_bvalid",     64'(s_axi_bvalid), 64'b10);
    check("wr1_m_bready",     64'(m_axi_bready), 64'd1);
    check("wr1_s_bid",        64'(s_axi_bid),    64'h55);
    step();
    m_axi_bvalid = 1'b0; s_axi_bready = '0;
    #1;
    check("wr1_done_grant", 64'(status_wr_grant), 64'd0);
    check("wr1_done_idle",  64'(status_idle),     64'd1);

    // ---------------- Round-robin reads: 0,1,0,1 ----------------
    s_axi_araddr[0 +: 64]  = 64'h2000;
    s_axi_araddr[64 +: 64] = 64'h3000;
    s_axi_arvalid = 2'b11;
    m_axi_arready = 1'b1;
    s_axi_rready  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  exp_g;
      logic [63:0] exp_a;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 64'h2000 : 64'h3000;
      step(); #1;
      check("rr_grant",   64'(status_rd_grant), 64'(exp_g));
      check("rr_araddr",  m_axi_araddr,         exp_a);
      check("rr_arvalid", 64'(m_axi_arvalid),   64'd1);
      step();
      m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
      #1;
      check("rr_no_ar_in_data", 64'(m_axi_arvalid), 64'd0);
      check("rr_s_rvalid",      64'(s_axi_rvalid),  64'(exp_g));
      step();
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      #1;
      check("rr_back_idle", 64'(status_rd_grant), 64'd0);
    end
    s_axi_arvalid = '0; s_axi_rready = '0;

    // ---------------- Concurrent write (client 0) and read (client 1) ----------------
    s_axi_awaddr[0 +: 64] = 64'h4000;
    s_axi_wstrb[0 +: 64]  = 64'hffff_ffff_ffff_ffff;
    s_axi_wlast   = 2'b01;
    s_axi_awvalid = 2'b01; s_axi_wvalid = 2'b01;
    s_axi_arvalid = 2'b10;
    step(); #1;
    check("cc_wr_grant", 64'(status_wr_grant), 64'b01);
    check("cc_rd_grant", 64'(status_rd_grant), 64'b10);
    check("cc_awaddr",   m_axi_awaddr,         64'h4000);
    check("cc_araddr",   m_axi_araddr,         64'h3000);
    check("cc_both_valid", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'b111);
    check("cc_not_idle", 64'(status_idle),     64'd0);
    step();
    s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_arvalid = '0;
    m_axi_bvalid = 1'b1; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    s_axi_bready = 2'b11; s_axi_rready = 2'b11;
    #1;
    check("cc_s_bvalid", 64'(s_axi_bvalid), 64'b01);
    check("cc_s_rvalid", 64'(s_axi_rvalid), 64'b10);
    step();
    m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    s_axi_bready = '0; s_axi_rready = '0;
    #1;
    check("cc_idle", 64'(status_idle), 64'd1);

    // ---------------- W three cycles before AW, then B backpressure ----------------
    s_axi_wlast   = 2'b10;
    s_axi_awvalid = 2'b10; s_axi_wvalid = 2'b10;
    m_axi_awready = 1'b0;  m_axi_wready = 1'b1;
    step(); #1;
    check("ord_m_wvalid",   64'(m_axi_wvalid),  64'd1);
    check("ord_s_awready",  64'(s_axi_awready), 64'd0);
    step(); #1;
    check("ord_w_done_gate", 64'(m_axi_wvalid), 64'd0);
    check("ord_s_wready",    64'(s_axi_wready), 64'd0);
    step(); step();
    m_axi_awready = 1'b1;
    #1;
    check("ord_m_awvalid", 64'(m_axi_awvalid), 64'd1);
    check("ord_grant",     64'(status_wr_grant), 64'b10);
    step();
    s_axi_awvalid = '0; s_axi_wvalid = '0;
    m_axi_bvalid = 1'b1; m_axi_bid = 16'h0077;
    s_axi_bready = '0;
    #1;
    check("ord_resp_awvalid", 64'(m_axi_awvalid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("bp_s_bvalid", 64'(s_axi_bvalid),    64'b10);
      check("bp_m_bready", 64'(m_axi_bready),    64'd0);
      step(); #1;
    end
    check("bp_still_resp", 64'(status_wr_grant), 64'b10);
    s_axi_bready = 2'b10;
    #1;
    check("bp_m_bready_on", 64'(m_axi_bready), 64'd1);
    check("bp_s_bid",       64'(s_axi_bid),    64'h77);
    step();
    m_axi_bvalid = 1'b0; s_axi_bready = '0;
    #1;
    check("bp_done_grant", 64'(status_wr_grant), 64'd0);

    // ---------------- Mid-transaction reset in DATA ----------------
    // Client 0 read leaves the pointer at 0 so client 1 would be next without a reset.
    s_axi_arvalid = 2'b01;
    step(); #1;
    check("mr_c0_grant", 64'(status_rd_grant), 64'b01);
    step();
    s_axi_arvalid = '0;
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; s_axi_rready = 2'b01;
    step();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready = '0;
    s_axi_arvalid = 2'b10;
    step(); #1;
    check("mr_c1_grant", 64'(status_rd_grant), 64'b10);
    step();
    s_axi_arvalid = '0;
    m_axi_rvalid = 1'b1;
    #1;
    check("mr_data_rvalid", 64'(s_axi_rvalid), 64'b10);
    nreset = 1'b0;
    #1;
    check("mr_rst_rvalid",  64'(s_axi_rvalid),    64'd0);
    check("mr_rst_grant",   64'(status_rd_grant), 64'd0);
    check("mr_rst_idle",    64'(status_idle),     64'd1);
    s_axi_arvalid = 2'b11;
    m_axi_rvalid = 1'b0;
    #2;
    nreset = 1'b1;
    step(); #1;
    check("mr_prio_c0", 64'(status_rd_grant), 64'b01);
    check("mr_araddr",  m_axi_araddr,         64'h2000);
    s_axi_arvalid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
